// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface mc_controller_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic        reg_write;
  logic [1:0]  reg_wa_sel;
  logic [1:0]  reg_wd_sel;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic        ext_op;
  logic        mem_req;
  logic        mem_we;
  logic        instr_done;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output ir_write, pc_write, pc_sel, reg_write, reg_wa_sel, reg_wd_sel,
           alu_op, alu_src, ext_op, mem_req, mem_we, instr_done,
           cycle_cnt, instr_cnt
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  ir_write, pc_write, pc_sel, reg_write, reg_wa_sel, reg_wd_sel,
           alu_op, alu_src, ext_op, mem_req, mem_we, instr_done,
           cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencer
// driving datapath strobes combinationally from state and opcode/funct.
// Optional feature: define PERF_CNT_EN to enable cycle/instruction counters;
// otherwise both counter outputs are tied to zero.
module mc_controller (
  input logic            clk,
  input logic            reset,
  mc_controller_if.master ctrl
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t state;
  state_t state_next;

  logic       is_addu, is_subu, is_jr, is_ori, is_lui;
  logic       is_lw, is_sw, is_beq, is_j, is_jal, is_exec;

  logic       ir_write, pc_write, reg_write, alu_src, ext_op;
  logic       mem_req, mem_we, instr_done;
  logic [1:0] pc_sel, reg_wa_sel, reg_wd_sel;
  logic [2:0] alu_op;

  // Instruction class decode from the latched opcode/funct
  always_comb begin
    is_addu = (ctrl.opcode == OP_RTYPE) && (ctrl.funct == FN_ADDU);
    is_subu = (ctrl.opcode == OP_RTYPE) && (ctrl.funct == FN_SUBU);
    is_jr   = (ctrl.opcode == OP_RTYPE) && (ctrl.funct == FN_JR);
    is_ori  = (ctrl.opcode == OP_ORI);
    is_lui  = (ctrl.opcode == OP_LUI);
    is_lw   = (ctrl.opcode == OP_LW);
    is_sw   = (ctrl.opcode == OP_SW);
    is_beq  = (ctrl.opcode == OP_BEQ);
    is_j    = (ctrl.opcode == OP_J);
    is_jal  = (ctrl.opcode == OP_JAL);
    is_exec = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // Next-state and output decode; everything is held at zero while in reset
  // so strobes (including a pending mem_req) drop in the reset cycle itself
  always_comb begin
    state_next = FETCH;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 2'b00;
    reg_write  = 1'b0;
    reg_wa_sel = 2'b00;
    reg_wd_sel = 2'b00;
    alu_op     = 3'b000;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    instr_done = 1'b0;
    if (reset) begin
      unique case (state)
        FETCH: begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
        DECODE: begin
          if (is_j || is_jal) begin
            pc_write   = 1'b1;
            pc_sel     = 2'b10;
            instr_done = 1'b1;
            if (is_jal) begin
              reg_write  = 1'b1;
              reg_wa_sel = 2'b10;
              reg_wd_sel = 2'b10;
            end
          end else if (is_jr) begin
            pc_write   = 1'b1;
            pc_sel     = 2'b11;
            instr_done = 1'b1;
          end else if (is_exec) begin
            state_next = EXEC;
          end else begin
            instr_done = 1'b1;
          end
        end
        EXEC: begin
          if (is_addu) begin
            state_next = WB;
          end else if (is_subu) begin
            alu_op     = 3'b001;
            state_next = WB;
          end else if (is_ori) begin
            alu_op     = 3'b010;
            alu_src    = 1'b1;
            state_next = WB;
          end else if (is_lui) begin
            alu_op     = 3'b011;
            alu_src    = 1'b1;
            state_next = WB;
          end else if (is_lw || is_sw) begin
            alu_src    = 1'b1;
            ext_op     = 1'b1;
            state_next = MEM;
          end else if (is_beq) begin
            alu_op     = 3'b001;
            ext_op     = 1'b1;
            instr_done = 1'b1;
            if (ctrl.zero) begin
              pc_write = 1'b1;
              pc_sel   = 2'b01;
            end
          end
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = is_sw;
          alu_src = 1'b1;
          ext_op  = 1'b1;
          if (!ctrl.mem_ready) begin
            state_next = MEM;
          end else if (is_lw) begin
            state_next = WB;
          end else begin
            instr_done = 1'b1;
          end
        end
        WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          if (is_ori || is_lui) begin
            reg_wa_sel = 2'b01;
          end else if (is_lw) begin
            reg_wa_sel = 2'b01;
            reg_wd_sel = 2'b01;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  assign ctrl.ir_write   = ir_write;
  assign ctrl.pc_write   = pc_write;
  assign ctrl.pc_sel     = pc_sel;
  assign ctrl.reg_write  = reg_write;
  assign ctrl.reg_wa_sel = reg_wa_sel;
  assign ctrl.reg_wd_sel = reg_wd_sel;
  assign ctrl.alu_op     = alu_op;
  assign ctrl.alu_src    = alu_src;
  assign ctrl.ext_op     = ext_op;
  assign ctrl.mem_req    = mem_req;
  assign ctrl.mem_we     = mem_we;
  assign ctrl.instr_done = instr_done;

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  // Free-running cycle counter and retired-instruction counter, both wrapping
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instr_cnt <= instr_cnt + 32'd1;
    end
  end

  assign ctrl.cycle_cnt = cycle_cnt;
  assign ctrl.instr_cnt = instr_cnt;
`else
  assign ctrl.cycle_cnt = '0;
  assign ctrl.instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes the hand-computed
// per-cycle output vector, a negedge monitor pops and compares.
module tb_mc_controller;

  logic clk;
  logic reset;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_JR   = 6'b001000;

  typedef struct {
    logic [16:0] sig;
    bit          chk;
    logic [31:0] cyc;
    logic [31:0] ins;
    string       tag;
  } exp_t;

  exp_t q[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  bit          chk_pending = 0;
  logic [31:0] chk_cyc = '0;
  logic [31:0] chk_ins = '0;

  // {ir,pcw,pc_sel,rw,wa,wd,alu_op,src,ext,mreq,mwe,done}
  function automatic logic [16:0] v(input logic ir, input logic pcw,
      input logic [1:0] ps, input logic rw, input logic [1:0] wa,
      input logic [1:0] wd, input logic [2:0] aop, input logic src,
      input logic ext, input logic mreq, input logic mwe, input logic done);
    return {ir, pcw, ps, rw, wa, wd, aop, src, ext, mreq, mwe, done};
  endfunction

  function automatic logic [16:0] fe();
    return v(1, 1, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0, 0, 0, 0, 0);
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic mr,
                     input logic [16:0] e);
    exp_t x;
    reset         = rst;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = mr;
    x.sig = e;
    x.tag = tag;
    x.chk = chk_pending;
`ifdef PERF_CNT_EN
    x.cyc = chk_cyc;
    x.ins = chk_ins;
`else
    x.cyc = '0;
    x.ins = '0;
`endif
    chk_pending = 0;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic go(input string tag, input logic [5:0] op, input logic [5:0] fn,
                    input logic z, input logic mr, input logic [16:0] e);
    cyc(tag, 1'b1, op, fn, z, mr, e);
  endtask

  task automatic want_cnt(input logic [31:0] c, input logic [31:0] i);
    chk_pending = 1;
    chk_cyc     = c;
    chk_ins     = i;
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectation
  initial begin
    logic [16:0] act;
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x   = q.pop_front();
        act = {bus.ir_write, bus.pc_write, bus.pc_sel, bus.reg_write,
               bus.reg_wa_sel, bus.reg_wd_sel, bus.alu_op, bus.alu_src,
               bus.ext_op, bus.mem_req, bus.mem_we, bus.instr_done};
        n_total++;
        if (act === x.sig) n_pass++;
        else $display("FAIL %s: got %b want %b", x.tag, act, x.sig);
        if (x.chk) begin
          n_total++;
          if (bus.cycle_cnt === x.cyc && bus.instr_cnt === x.ins) n_pass++;
          else $display("FAIL %s_cnt: got cyc=%0d ins=%0d want cyc=%0d ins=%0d",
                        x.tag, bus.cycle_cnt, bus.instr_cnt, x.cyc, x.ins);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [16:0] z0;
    z0 = '0;
    reset = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      if (i == 2) want_cnt(0, 0);
      cyc("reset", 1'b0, OP_SW, 6'd0, 1'b1, 1'b1, z0);
    end

    // sw with mem_ready tied high, then jr
    go("sw_f", OP_SW, 0, 0, 1, fe());
    go("sw_d", OP_SW, 0, 0, 1, z0);
    go("sw_e", OP_SW, 0, 0, 1, v(0,0,2'b00,0,2'b00,2'b00,3'b000,1,1,0,0,0));
    go("sw_m", OP_SW, 0, 0, 1, v(0,0,2'b00,0,2'b00,2'b00,3'b000,1,1,1,1,1));
    go("jr_f", OP_R, F_JR, 0, 1, fe());
    go("jr_d", OP_R, F_JR, 0, 1, v(0,1,2'b11,0,2'b00,2'b00,3'b000,0,0,0,0,1));

    // addu, with counter check on its fetch
    want_cnt(6, 2);
    go("addu_f", OP_R, F_ADDU, 0, 0, fe());
    go("addu_d", OP_R, F_ADDU, 0, 0, z0);
    go("addu_e", OP_R, F_ADDU, 0, 0, z0);
    go("addu_wb", OP_R, F_ADDU, 0, 0, v(0,0,2'b00,1,2'b00,2'b00,3'b000,0,0,0,0,1));

    // lw with two wait cycles
    go("lw_f", OP_LW, 0, 0, 0, fe());
    go("lw_d", OP_LW, 0, 0, 0, z0);
    go("lw_e", OP_LW, 0, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b000,1,1,0,0,0));
    go("lw_m0", OP_LW, 0, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b000,1,1,1,0,0));
    go("lw_m1", OP_LW, 0, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b000,1,1,1,0,0));
    go("lw_m2", OP_LW, 0, 0, 1, v(0,0,2'b00,0,2'b00,2'b00,3'b000,1,1,1,0,0));
    go("lw_wb", OP_LW, 0, 0, 0, v(0,0,2'b00,1,2'b01,2'b01,3'b000,0,0,0,0,1));

    // beq taken / not taken
    go("beq1_f", OP_BEQ, 0, 1, 0, fe());
    go("beq1_d", OP_BEQ, 0, 1, 0, z0);
    go("beq1_e", OP_BEQ, 0, 1, 0, v(0,1,2'b01,0,2'b00,2'b00,3'b001,0,1,0,0,1));
    go("beq0_f", OP_BEQ, 0, 0, 0, fe());
    go("beq0_d", OP_BEQ, 0, 0, 0, z0);
    go("beq0_e", OP_BEQ, 0, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b001,0,1,0,0,1));

    // jal, j
    go("jal_f", OP_JAL, 0, 0, 0, fe());
    go("jal_d", OP_JAL, 0, 0, 0, v(0,1,2'b10,1,2'b10,2'b10,3'b000,0,0,0,0,1));
    go("j_f", OP_J, 0, 0, 0, fe());
    go("j_d", OP_J, 0, 0, 0, v(0,1,2'b10,0,2'b00,2'b00,3'b000,0,0,0,0,1));

    // ori, lui, subu
    go("ori_f", OP_ORI, 0, 0, 0, fe());
    go("ori_d", OP_ORI, 0, 0, 0, z0);
    go("ori_e", OP_ORI, 0, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b010,1,0,0,0,0));
    go("ori_wb", OP_ORI, 0, 0, 0, v(0,0,2'b00,1,2'b01,2'b00,3'b000,0,0,0,0,1));
    go("lui_f", OP_LUI, 0, 0, 0, fe());
    go("lui_d", OP_LUI, 0, 0, 0, z0);
    go("lui_e", OP_LUI, 0, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b011,1,0,0,0,0));
    go("lui_wb", OP_LUI, 0, 0, 0, v(0,0,2'b00,1,2'b01,2'b00,3'b000,0,0,0,0,1));
    go("subu_f", OP_R, F_SUBU, 0, 0, fe());
    go("subu_d", OP_R, F_SUBU, 0, 0, z0);
    go("subu_e", OP_R, F_SUBU, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b001,0,0,0,0,0));
    go("subu_wb", OP_R, F_SUBU, 0, 0, v(0,0,2'b00,1,2'b00,2'b00,3'b000,0,0,0,0,1));

    // unsupported opcode and unsupported R funct behave as NOPs
    go("nop_f", OP_BAD, 0, 0, 0, fe());
    go("nop_d", OP_BAD, 0, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b000,0,0,0,0,1));
    go("nopr_f", OP_R, 6'b000000, 0, 0, fe());
    go("nopr_d", OP_R, 6'b000000, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b000,0,0,0,0,1));

    // reset asserted during a MEM wait
    go("lwr_f", OP_LW, 0, 0, 0, fe());
    go("lwr_d", OP_LW, 0, 0, 0, z0);
    go("lwr_e", OP_LW, 0, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b000,1,1,0,0,0));
    go("lwr_m", OP_LW, 0, 0, 0, v(0,0,2'b00,0,2'b00,2'b00,3'b000,1,1,1,0,0));
    cyc("lwr_rst0", 1'b0, OP_LW, 0, 0, 0, z0);
    want_cnt(0, 0);
    cyc("lwr_rst1", 1'b0, OP_LW, 0, 0, 0, z0);
    want_cnt(0, 0);
    go("post_f", OP_R, F_ADDU, 0, 0, fe());
    go("post_d", OP_R, F_ADDU, 0, 0, z0);
    go("post_e", OP_R, F_ADDU, 0, 0, z0);
    go("post_wb", OP_R, F_ADDU, 0, 0, v(0,0,2'b00,1,2'b00,2'b00,3'b000,0,0,0,0,1));
    want_cnt(4, 1);
    go("end_f", OP_R, F_ADDU, 0, 0, fe());

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
